uart_tx: RTL and testbench

- UART transmitter, the sending end of the 11-bit frame used by uart_rx: start(0), 8 data bits LSB first, parity bit, stop(1).
- Runs on the baud x16 clock and shares the free-running 4-bit cnt16x counter with the receiver.
- A double buffer (CPU holding register plus frame shift register) allows back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_if.sv | 27 ++
 rtl/uart_tx.sv | 103 ++++++++++
 tb/tb_uart_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART frame definitions: frame geometry, transmitter states and the frame builder.
// The receiver checks against the same builder, so the line format is defined in one place.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Index of the stop bit in the frame; also the bit counter's final value.
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  // Bit 0 goes on the line first: {stop, parity, data[7:0], start}.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [DATA_BITS-1:0] data,
    input logic                 odd
  );
    logic parity;
    parity = odd ? ~^data : ^data;
    return {STOP_BIT, parity, data, START_BIT};
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side port of the UART transmitter: write strobe and data in, buffer status out.
// The CPU writes one byte per single-cycle wrn strobe while t_empty is high.
interface uart_tx_if;

  logic       wrn;
  logic [7:0] d_in;
  logic       t_empty;
  logic       t_busy;
  logic       overrun;

  modport master (
    output wrn,
    output d_in,
    input  t_empty,
    input  t_busy,
    input  overrun
  );

  modport slave (
    input  wrn,
    input  d_in,
    output t_empty,
    output t_busy,
    output overrun
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter on the x16 clock; a frame starts on the first cnt16x==0 tick after a write.
// Holding register plus shift register give gapless back-to-back frames; writes while full set overrun.
module uart_tx
  import uart_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic       clk16x,
  input  logic       clrn,
  input  logic [3:0] cnt16x,
  output logic       txd,
  uart_tx_if.slave   bus
);

  tx_state_t             state;
  logic [DATA_BITS-1:0]  hold;
  logic [FRAME_BITS-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic                  empty_q;
  logic                  busy_q;
  logic                  ovr_q;

  logic                  tick;
  logic                  last_bit;
  logic                  load;
  logic                  accept;
  logic [FRAME_BITS-1:0] next_frame;

  always_comb begin
    tick       = (cnt16x == 4'd0);
    last_bit   = (bit_cnt == LAST_BIT);
    // A transfer frees the holding register on the same edge, so a write there is accepted too.
    load       = tick && !empty_q && ((state == TX_IDLE) || last_bit);
    accept     = !bus.wrn && (empty_q || load);
    next_frame = build_frame(hold, ODD_PARITY);
  end

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      state   <= TX_IDLE;
      hold    <= '0;
      shreg   <= '0;
      bit_cnt <= 4'd0;
      empty_q <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      txd     <= 1'b1;
    end else begin
      if (accept) begin
        hold    <= bus.d_in;
        empty_q <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        if (load) begin
          empty_q <= 1'b1;
        end
        if (!bus.wrn) begin
          ovr_q <= 1'b1;
        end
      end

      case (state)
        TX_IDLE: begin
          if (load) begin
            shreg   <= next_frame;
            txd     <= START_BIT;
            bit_cnt <= 4'd0;
            busy_q  <= 1'b1;
            state   <= TX_SEND;
          end else begin
            txd    <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        TX_SEND: begin
          if (tick) begin
            if (!last_bit) begin
              bit_cnt <= bit_cnt + 4'd1;
              shreg   <= {STOP_BIT, shreg[FRAME_BITS-1:1]};
              txd     <= shreg[1];
            end else if (load) begin
              // Stop bit has run its full 16 cycles; chain straight into the next start bit.
              shreg   <= next_frame;
              txd     <= START_BIT;
              bit_cnt <= 4'd0;
            end else begin
              txd     <= 1'b1;
              bit_cnt <= 4'd0;
              busy_q  <= 1'b0;
              state   <= TX_IDLE;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  assign bus.t_empty = empty_q;
  assign bus.t_busy  = busy_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame contents, timing, double buffering, overrun, reset and loopback.
module tb_uart_tx;

  logic       clk16x;
  logic       clrn;
  logic [3:0] cnt16x;
  logic       txd;
  logic       txd_odd;

  int checks = 0;
  int errors = 0;

  uart_tx_if bus ();
  uart_tx_if bus_odd ();

  uart_tx #(.ODD_PARITY(1'b0)) dut (
    .clk16x (clk16x),
    .clrn   (clrn),
    .cnt16x (cnt16x),
    .txd    (txd),
    .bus    (bus)
  );

  uart_tx #(.ODD_PARITY(1'b1)) dut_odd (
    .clk16x (clk16x),
    .clrn   (clrn),
    .cnt16x (cnt16x),
    .txd    (txd_odd),
    .bus    (bus_odd)
  );

  initial begin
    clk16x = 1'b0;
    forever #5 clk16x = ~clk16x;
  end

  // Free-running shared counter, updated well away from both clock edges.
  initial begin
    cnt16x = 4'd0;
    forever begin
      @(posedge clk16x);
      #2;
      cnt16x = cnt16x + 4'd1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic line_of(input bit sel);
    return sel ? txd_odd : txd;
  endfunction

  task automatic write_byte(input logic [7:0] b);
    bus.wrn  = 1'b0;
    bus.d_in = b;
    @(negedge clk16x);
    bus.wrn  = 1'b1;
  endtask

  task automatic write_both(input logic [7:0] b);
    bus.wrn      = 1'b0;
    bus.d_in     = b;
    bus_odd.wrn  = 1'b0;
    bus_odd.d_in = b;
    @(negedge clk16x);
    bus.wrn      = 1'b1;
    bus_odd.wrn  = 1'b1;
  endtask

  task automatic wait_empty();
    bit found;
    found = 1'b0;
    for (int w = 0; w < 400 && !found; w++) begin
      if (bus.t_empty === 1'b1) found = 1'b1;
      else @(negedge clk16x);
    end
    if (!found) check("wait_empty_timeout", 16'd0, 16'd1);
  endtask

  // Finds the start edge, then samples each bit in the middle of its 16-cycle slot.
  task automatic rx_frame(input bit sel, output logic [10:0] f, output int gap,
                          output logic e_at_start);
    bit found;
    found      = 1'b0;
    f          = '0;
    gap        = -1;
    e_at_start = 1'bx;
    for (int w = 0; w < 40 && !found; w++) begin
      if (line_of(sel) === 1'b0) begin
        found = 1'b1;
        gap   = w;
      end else begin
        @(negedge clk16x);
      end
    end
    if (!found) begin
      check("rx_start_timeout", 16'd0, 16'd1);
      return;
    end
    e_at_start = sel ? bus_odd.t_empty : bus.t_empty;
    check("rx_start_on_tick", {12'd0, cnt16x}, 16'd1);
    repeat (8) @(negedge clk16x);
    for (int i = 0; i < 11; i++) begin
      f[i] = line_of(sel);
      if (i < 10) repeat (16) @(negedge clk16x);
    end
  endtask

  task automatic busy_len(output int n);
    n = 0;
    for (int w = 0; w < 40 && bus.t_busy !== 1'b1; w++) @(negedge clk16x);
    while (bus.t_busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk16x);
    end
  endtask

  logic [10:0] fa, fb;
  int          ga, gb, nb;
  logic        ea, eb;
  logic [7:0]  bytes [200];

  initial begin
    clrn         = 1'b0;
    bus.wrn      = 1'b1;
    bus.d_in     = 8'h00;
    bus_odd.wrn  = 1'b1;
    bus_odd.d_in = 8'h00;
    repeat (5) @(negedge clk16x);

    check("reset_txd", {15'd0, txd}, 16'd1);
    check("reset_t_empty", {15'd0, bus.t_empty}, 16'd1);
    check("reset_t_busy", {15'd0, bus.t_busy}, 16'd0);
    check("reset_overrun", {15'd0, bus.overrun}, 16'd0);
    clrn = 1'b1;
    repeat (3) @(negedge clk16x);

    // Single frame 0x55 from idle.
    write_byte(8'h55);
    check("h55_t_empty_after_write", {15'd0, bus.t_empty}, 16'd0);
    fork
      rx_frame(1'b0, fa, ga, ea);
      busy_len(nb);
    join
    check("h55_frame", {5'd0, fa}, 16'h04AA);
    check("h55_t_empty_at_load", {15'd0, ea}, 16'd1);
    check("h55_busy_cycles", nb[15:0], 16'd176);
    repeat (3) @(negedge clk16x);

    // Parity of 0x01: even instance sends 1, odd instance sends 0.
    write_both(8'h01);
    fork
      rx_frame(1'b0, fa, ga, ea);
      rx_frame(1'b1, fb, gb, eb);
    join
    check("h01_even_frame", {5'd0, fa}, 16'h0602);
    check("h01_odd_frame", {5'd0, fb}, 16'h0402);
    repeat (20) @(negedge clk16x);

    // Back-to-back 0xA3, 0x3C with no idle gap.
    write_byte(8'hA3);
    fork
      begin
        rx_frame(1'b0, fa, ga, ea);
        rx_frame(1'b0, fb, gb, eb);
      end
      busy_len(nb);
      begin
        wait_empty();
        write_byte(8'h3C);
      end
    join
    check("hA3_frame", {5'd0, fa}, 16'h0546);
    check("h3C_frame", {5'd0, fb}, 16'h0478);
    check("b2b_gap_negedges", gb[15:0], 16'd8);
    check("b2b_busy_cycles", nb[15:0], 16'd352);
    repeat (3) @(negedge clk16x);

    // Overrun: 0x22 fills the holding register, 0x33 is dropped.
    write_byte(8'h11);
    fork
      begin
        rx_frame(1'b0, fa, ga, ea);
        rx_frame(1'b0, fb, gb, eb);
      end
      begin
        wait_empty();
        write_byte(8'h22);
        check("h22_t_empty", {15'd0, bus.t_empty}, 16'd0);
        check("h22_no_overrun", {15'd0, bus.overrun}, 16'd0);
        write_byte(8'h33);
        check("h33_overrun", {15'd0, bus.overrun}, 16'd1);
      end
    join
    check("h11_frame", {5'd0, fa}, 16'h0422);
    check("h22_frame", {5'd0, fb}, 16'h0444);
    for (int w = 0; w < 200 && bus.t_busy === 1'b1; w++) @(negedge clk16x);
    repeat (40) @(negedge clk16x);
    check("no_third_frame_busy", {15'd0, bus.t_busy}, 16'd0);
    check("no_third_frame_txd", {15'd0, txd}, 16'd1);
    check("overrun_held", {15'd0, bus.overrun}, 16'd1);
    write_byte(8'h5A);
    check("overrun_cleared", {15'd0, bus.overrun}, 16'd0);
    rx_frame(1'b0, fa, ga, ea);
    check("h5A_frame", {5'd0, fa}, 16'h04B4);
    repeat (20) @(negedge clk16x);

    // Reset in the middle of data bit 4 of 0xFF.
    write_byte(8'hFF);
    begin
      bit found;
      found = 1'b0;
      for (int w = 0; w < 40 && !found; w++) begin
        if (txd === 1'b0) found = 1'b1;
        else @(negedge clk16x);
      end
      if (!found) check("hFF_start_timeout", 16'd0, 16'd1);
    end
    repeat (8 + 16 * 5) @(negedge clk16x);
    check("hFF_busy_before_reset", {15'd0, bus.t_busy}, 16'd1);
    clrn = 1'b0;
    #1;
    check("midframe_reset_txd", {15'd0, txd}, 16'd1);
    check("midframe_reset_busy", {15'd0, bus.t_busy}, 16'd0);
    check("midframe_reset_empty", {15'd0, bus.t_empty}, 16'd1);
    repeat (3) @(negedge clk16x);
    clrn = 1'b1;
    @(negedge clk16x);
    write_byte(8'h0F);
    rx_frame(1'b0, fa, ga, ea);
    check("h0F_after_reset_frame", {5'd0, fa}, 16'h041E);
    repeat (20) @(negedge clk16x);

    // Loopback of 200 random bytes through a line-level receiver model.
    for (int i = 0; i < 200; i++) bytes[i] = 8'($urandom_range(0, 255));
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          wait_empty();
          write_byte(bytes[i]);
        end
      end
      begin
        for (int i = 0; i < 200; i++) begin
          logic [10:0] f;
          int          g;
          logic        e;
          rx_frame(1'b0, f, g, e);
          check("loopback_frame", {5'd0, f},
                {5'd0, 1'b1, ^bytes[i], bytes[i], 1'b0});
        end
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
